// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Brings a raw asynchronous level (switch, trigger, external strobe) into the
// clk domain through a plain flop chain, then accepts a new level only after
// DEBOUNCE_CYCLES consecutive synchronized samples agree. Single-cycle rise
// and fall pulses mark each accepted change of the debounced level.
//
// Parameters
//   SYNC_STAGES      synchronizer depth, 2..4
//   DEBOUNCE_CYCLES  consecutive agreeing samples needed, 1..2^CNT_W-1
//   CNT_W            debounce counter width
//   INIT_LEVEL       level of the synchronizer and dout while in reset
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   din    in   raw asynchronous input level
//   dout   out  registered debounced level
//   rise   out  registered one-cycle pulse when dout goes 0->1
//   fall   out  registered one-cycle pulse when dout goes 1->0
// -----------------------------------------------------------------------------
module sync_debounce #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1000,
   parameter int   CNT_W           = 16,
   parameter logic INIT_LEVEL      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   // Parameter legality is checked while the design is elaborated so a bad
   // configuration never reaches synthesis.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("sync_debounce: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
   end
   if (DEBOUNCE_CYCLES < 1 ||
       longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_debounce
      $error("sync_debounce: DEBOUNCE_CYCLES=%0d does not fit CNT_W=%0d",
             DEBOUNCE_CYCLES, CNT_W);
   end

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      PEND_HI   = 2'd1,
      STABLE_HI = 2'd2,
      PEND_LO   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
   localparam state_t           RST_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   din_s;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_inc;

   // ---------------------------------------------------------------------------
   // Synchronizer: a bare shift chain with nothing between stages, so every
   // stage after the first gets a full cycle to resolve metastability.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is assigned with <= so every flop samples the values
   // from before the edge; with = the chain would collapse into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{INIT_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign din_s = sync_q[SYNC_STAGES-1];

   // cnt stays strictly below DEBOUNCE_CYCLES, so this never wraps.
   assign cnt_inc = cnt + 1'b1;

   // ---------------------------------------------------------------------------
   // Debounce FSM. dout, rise and fall are registered alongside the state so
   // dout moves on the very edge that enters STABLE_x and the pulse is visible
   // for the cycle that follows it. A PEND_x that sees the old level again
   // simply falls back without touching dout.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RST_STATE;
         cnt   <= '0;
         dout  <= INIT_LEVEL;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (din_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state <= STABLE_HI;
                     dout  <= 1'b1;
                     rise  <= 1'b1;
                  end else begin
                     state <= PEND_HI;
                     cnt   <= CNT_FIRST;
                  end
               end
            end
            PEND_HI: begin
               if (!din_s) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (cnt_inc == CNT_LAST) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
                  dout  <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            STABLE_HI: begin
               if (!din_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     state <= STABLE_LO;
                     dout  <= 1'b0;
                     fall  <= 1'b1;
                  end else begin
                     state <= PEND_LO;
                     cnt   <= CNT_FIRST;
                  end
               end
            end
            PEND_LO: begin
               if (din_s) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (cnt_inc == CNT_LAST) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
                  dout  <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
               dout  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//
// Drives one shared din/rst_n into two instances of sync_debounce
// (DEBOUNCE_CYCLES=4 and DEBOUNCE_CYCLES=1, both SYNC_STAGES=2, INIT_LEVEL=0).
// Each cycle a behavioural run-length model predicts the outputs of both
// instances; predictions are queued when din is driven and popped once the
// clock edge has produced the DUT response.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

   localparam int DEB4 = 4;
   localparam int DEB1 = 1;

   logic clk;
   logic rst_n;
   logic din;
   logic dout4, rise4, fall4;
   logic dout1, rise1, fall1;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        dout;
      logic        rise;
      logic        fall;
      logic [15:0] cnt;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];

   // Model state, index 0 = DEB4 instance, 1 = DEB1 instance.
   logic m_s0  [2];
   logic m_s1  [2];
   logic m_lvl [2];
   int   m_run [2];

   int rise1_seen;
   int fall1_seen;

   sync_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB4), .CNT_W(16), .INIT_LEVEL(1'b0)
   ) u_dut4 (
      .clk(clk), .rst_n(rst_n), .din(din), .dout(dout4), .rise(rise4), .fall(fall4)
   );

   sync_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB1), .CNT_W(16), .INIT_LEVEL(1'b0)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .dout(dout1), .rise(rise1), .fall(fall1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_s0[i]  = 1'b0;
         m_s1[i]  = 1'b0;
         m_lvl[i] = 1'b0;
         m_run[i] = 0;
      end
      q4.delete();
      q1.delete();
   endtask

   // Level is accepted once deb consecutive synchronized samples differ from
   // the current level; any agreeing sample restarts the run.
   task automatic model_step(input int i, input logic d, input int deb, output exp_t e);
      logic seen;
      seen    = m_s1[i];
      m_s1[i] = m_s0[i];
      m_s0[i] = d;
      e       = '0;
      if (seen != m_lvl[i]) begin
         m_run[i]++;
         if (m_run[i] == deb) begin
            m_lvl[i] = seen;
            m_run[i] = 0;
            e.rise   = seen;
            e.fall   = ~seen;
         end
      end else begin
         m_run[i] = 0;
      end
      e.dout = m_lvl[i];
      e.cnt  = 16'(m_run[i]);
   endtask

   // One clock: drive din on the falling edge, queue predictions, then compare
   // just after the rising edge.
   task automatic cycle(input logic d);
      exp_t e;
      @(negedge clk);
      din = d;
      model_step(0, d, DEB4, e);
      q4.push_back(e);
      model_step(1, d, DEB1, e);
      q1.push_back(e);
      @(posedge clk);
      #1;
      check("sb_depth4", q4.size(), 1);
      e = q4.pop_front();
      check("dout4", dout4, e.dout);
      check("rise4", rise4, e.rise);
      check("fall4", fall4, e.fall);
      check("cnt4", u_dut4.cnt, e.cnt);
      check("excl4", rise4 & fall4, 0);
      check("sb_depth1", q1.size(), 1);
      e = q1.pop_front();
      check("dout1", dout1, e.dout);
      check("rise1", rise1, e.rise);
      check("fall1", fall1, e.fall);
      check("excl1", rise1 & fall1, 0);
      if (rise1) rise1_seen++;
      if (fall1) fall1_seen++;
   endtask

   task automatic repeat_cycle(input logic d, input int n);
      for (int k = 0; k < n; k++) cycle(d);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_dout4"}, dout4, 0);
      check({tag, "_rise4"}, rise4, 0);
      check({tag, "_fall4"}, fall4, 0);
      check({tag, "_cnt4"}, u_dut4.cnt, 0);
      check({tag, "_dout1"}, dout1, 0);
      check({tag, "_rise1"}, rise1, 0);
      check({tag, "_fall1"}, fall1, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      din        = 1'b1;
      rise1_seen = 0;
      fall1_seen = 0;
      model_reset();

      // Power-up with din high held through reset.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check_reset_vals("por");
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat_cycle(1'b1, 8);

      // Clean fall from STABLE_HI.
      repeat_cycle(1'b0, 8);

      // Glitch: three synchronized high samples never reach DEBOUNCE_CYCLES.
      repeat_cycle(1'b1, 3);
      check("glitch_cnt_peak", u_dut4.cnt, 1);
      repeat_cycle(1'b0, 6);

      // Bounce: high 2, low 1, then steady high.
      repeat_cycle(1'b1, 2);
      cycle(1'b0);
      repeat_cycle(1'b1, 8);

      // Return low, then start a pending rise and reset it at cnt=3.
      repeat_cycle(1'b0, 8);
      repeat_cycle(1'b1, 5);
      check("pend_cnt_before_rst", u_dut4.cnt, 3);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check_reset_vals("hold_rst");
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      repeat_cycle(1'b1, 8);

      // Square wave of period 6.
      repeat_cycle(1'b0, 8);
      rise1_seen = 0;
      fall1_seen = 0;
      for (int p = 0; p < 4; p++) begin
         repeat_cycle(1'b1, 3);
         repeat_cycle(1'b0, 3);
      end
      repeat_cycle(1'b0, 3);
      check("sq_rise_count1", rise1_seen, 4);
      check("sq_fall_count1", fall1_seen, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops; legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, consecutive synchronized samples needed to accept a new level; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16, debounce counter width.
REQ-004 Parameter INIT_LEVEL, default 0, level taken by the synchronizer flops and by dout during reset.
REQ-005 Port: clk  input  1  single clock; all flops on its rising edge.
REQ-006 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 Port: din  input  1  raw asynchronous level (switch, trigger, external strobe).
REQ-008 Port: dout  output  1  registered, debounced, synchronized level; feeds the downstream edge detector directly.
REQ-009 Port: rise  output  1  registered, one-cycle pulse on the cycle dout goes 0->1.
REQ-010 Port: fall  output  1  registered, one-cycle pulse on the cycle dout goes 1->0.

Function
REQ-011 din passes through a SYNC_STAGES-deep flop chain; the last stage is din_s; no logic sits between chain stages.
REQ-012 FSM states: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO; dout=0 in STABLE_LO/PEND_HI and dout=1 in STABLE_HI/PEND_LO.
REQ-013 STABLE_LO with din_s=1: go to PEND_HI, cnt<=1; if DEBOUNCE_CYCLES=1, go directly to STABLE_HI instead.
REQ-014 PEND_HI with din_s=1: cnt<=cnt+1; when cnt+1 equals DEBOUNCE_CYCLES, go to STABLE_HI and clear cnt to 0.
REQ-015 PEND_HI with din_s=0: return to STABLE_LO and clear cnt to 0; dout is unchanged and no pulse is produced.
REQ-016 STABLE_HI and PEND_LO mirror REQ-013..REQ-015 with the polarities inverted.
REQ-017 dout changes on the same edge as the STABLE_x transition.
REQ-018 rise or fall is high only in the cycle that immediately follows that edge; rise and fall are never high together.
REQ-019 Latency: a clean din step sampled at edge k appears on dout after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-020 cnt never exceeds DEBOUNCE_CYCLES and never wraps; in STABLE_x states cnt=0.
REQ-021 An elaboration-time check fails if DEBOUNCE_CYCLES>2^CNT_W-1 or SYNC_STAGES<2.
REQ-022 A din pulse shorter than DEBOUNCE_CYCLES synchronized samples never changes dout.

Reset
REQ-023 While rst_n=0, regardless of clk or din:
- synchronizer flops = INIT_LEVEL
- dout = INIT_LEVEL
- state = STABLE_LO (INIT_LEVEL=0) or STABLE_HI (INIT_LEVEL=1)
- cnt = 0, rise = 0, fall = 0
REQ-024 Reset asserted mid-PEND abandons the pending transition; no pulse is emitted on entering or leaving reset.
REQ-025 After rst_n deasserts, the first edge resumes normal operation; a din level differing from INIT_LEVEL is debounced per REQ-019.

Verification
(SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INIT_LEVEL=0 unless stated.)
REQ-026 Power-up: din=1 held through reset, rst_n released before edge 0 -> dout=0 through edge 4, dout=1 after edge 5, rise=1 for exactly the cycle after edge 5, fall=0 throughout.
REQ-027 Glitch: din high for exactly 3 cycles, then low -> dout stays 0 and rise stays 0; cnt peaks at 3, then returns to 0.
REQ-028 Bounce: din high 2 cycles, low 1, then high steady -> PEND_HI aborts once; dout rises 5 edges after the first sample of the final high; exactly one rise pulse.
REQ-029 Clean fall from STABLE_HI: din 1->0 held -> dout falls after edge k+5, fall=1 for one cycle, rise=0.
REQ-030 Reset mid-pending: rst_n asserted asynchronously while in PEND_HI with cnt=3 -> outputs immediately at reset values (dout=0, cnt=0, rise=fall=0); with din still 1 after release, a full new 5-edge latency is observed.
REQ-031 DEBOUNCE_CYCLES=1: square-wave din with period 6 -> dout equals din delayed by exactly 2 edges; one rise and one fall per period.
